traffic_light_monitor: RTL and testbench

//  Passive checker on the light side of the trafficProblemFSM interface.
//  - Samples the encoded lights la/lb every clock.
//  - Flags safety and sequencing violations: conflicting right-of-way, illegal transitions,

---
 rtl/traffic_pkg.sv | 12 +
 rtl/light_tracker.sv | 70 +++++++
 rtl/traffic_light_monitor.sv | 117 +++++++++++
 tb/tb_traffic_light_monitor.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/traffic_pkg.sv
// rtl/traffic_pkg.sv - light encoding shared by the traffic controller and its monitor
package traffic_pkg;

  typedef enum logic [1:0] {
    RED    = 2'b00,
    YELLOW = 2'b01,
    GREEN  = 2'b10
  } light_t;

  localparam logic [1:0] ILLEGAL = 2'b11;

endpackage

// File: rtl/light_tracker.sv
// rtl/light_tracker.sv - per-road history (previous light, dwell run) and unregistered violation flags
module light_tracker
  import traffic_pkg::*;
#(
  parameter int GREEN_MIN  = 3,
  parameter int YELLOW_MIN = 2,
  parameter int CNT_W      = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] cur,
  output logic       seq_bad,
  output logic       dwell_bad,
  output logic       code_bad
);

  localparam logic [CNT_W-1:0] G_MIN     = CNT_W'(GREEN_MIN);
  localparam logic [CNT_W-1:0] Y_MIN     = CNT_W'(YELLOW_MIN);
  localparam logic [CNT_W-1:0] DWELL_MAX = {CNT_W{1'b1}};

  logic [1:0]       prev_q, prev_d;
  logic [CNT_W-1:0] dwell_q, dwell_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_q  <= RED;
      dwell_q <= '0;
    end else begin
      prev_q  <= prev_d;
      dwell_q <= dwell_d;
    end
  end

  always_comb begin
    prev_d    = prev_q;
    dwell_d   = dwell_q;
    seq_bad   = 1'b0;
    dwell_bad = 1'b0;
    code_bad  = (cur == ILLEGAL);

    if (cur == prev_q) begin
      dwell_d = (dwell_q == DWELL_MAX) ? dwell_q : dwell_q + 1'b1;
    end else begin
      dwell_d = CNT_W'(1);
      prev_d  = cur;
    end

    // Changes into or out of the illegal code are reported only as code errors.
    if ((cur != prev_q) && (cur != ILLEGAL) && (prev_q != ILLEGAL)) begin
      case (prev_q)
        RED: begin
          seq_bad = (cur == YELLOW);
        end
        GREEN: begin
          seq_bad   = (cur == RED);
          dwell_bad = (cur == YELLOW) && (dwell_q < G_MIN);
        end
        YELLOW: begin
          seq_bad   = (cur == GREEN);
          dwell_bad = (cur == RED) && (dwell_q < Y_MIN);
        end
        default: begin
          seq_bad   = 1'b0;
          dwell_bad = 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/traffic_light_monitor.sv
// rtl/traffic_light_monitor.sv - passive safety/sequencing checker on the la/lb light outputs
module traffic_light_monitor
  import traffic_pkg::*;
#(
  parameter int GREEN_MIN  = 3,
  parameter int YELLOW_MIN = 2,
  parameter int CNT_W      = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             clr,
  input  logic [1:0]       la,
  input  logic [1:0]       lb,
  output logic             err_conflict,
  output logic [1:0]       err_seq,
  output logic [1:0]       err_dwell,
  output logic [1:0]       err_code,
  output logic             err_sticky,
  output logic [CNT_W-1:0] viol_count
);

  localparam logic [CNT_W-1:0] COUNT_MAX = {CNT_W{1'b1}};

  logic [1:0] seq_raw, dwell_raw, code_raw;

  light_tracker #(
    .GREEN_MIN (GREEN_MIN),
    .YELLOW_MIN(YELLOW_MIN),
    .CNT_W     (CNT_W)
  ) u_track_a (
    .clk      (clk),
    .rst_n    (reset),
    .cur      (la),
    .seq_bad  (seq_raw[0]),
    .dwell_bad(dwell_raw[0]),
    .code_bad (code_raw[0])
  );

  light_tracker #(
    .GREEN_MIN (GREEN_MIN),
    .YELLOW_MIN(YELLOW_MIN),
    .CNT_W     (CNT_W)
  ) u_track_b (
    .clk      (clk),
    .rst_n    (reset),
    .cur      (lb),
    .seq_bad  (seq_raw[1]),
    .dwell_bad(dwell_raw[1]),
    .code_bad (code_raw[1])
  );

  logic             conflict_q, conflict_d;
  logic [1:0]       seq_q, seq_d;
  logic [1:0]       dwell_q, dwell_d;
  logic [1:0]       code_q, code_d;
  logic             sticky_q, sticky_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             any_err;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      conflict_q <= 1'b0;
      seq_q      <= '0;
      dwell_q    <= '0;
      code_q     <= '0;
      sticky_q   <= 1'b0;
      count_q    <= '0;
    end else begin
      conflict_q <= conflict_d;
      seq_q      <= seq_d;
      dwell_q    <= dwell_d;
      code_q     <= code_d;
      sticky_q   <= sticky_d;
      count_q    <= count_d;
    end
  end

  always_comb begin
    conflict_d = 1'b0;
    seq_d      = '0;
    dwell_d    = '0;
    code_d     = '0;
    sticky_d   = sticky_q;
    count_d    = count_q;

    if (en) begin
      conflict_d = (la != RED) && (lb != RED);
      seq_d      = seq_raw;
      dwell_d    = dwell_raw;
      code_d     = code_raw;
    end

    any_err = conflict_d | (|seq_d) | (|dwell_d) | (|code_d);

    // A fresh error on a clear edge restarts the count at one rather than zero.
    if (any_err) begin
      sticky_d = 1'b1;
      if (clr) begin
        count_d = CNT_W'(1);
      end else if (count_q != COUNT_MAX) begin
        count_d = count_q + 1'b1;
      end
    end else if (clr && en) begin
      sticky_d = 1'b0;
      count_d  = '0;
    end
  end

  assign err_conflict = conflict_q;
  assign err_seq      = seq_q;
  assign err_dwell    = dwell_q;
  assign err_code     = code_q;
  assign err_sticky   = sticky_q;
  assign viol_count   = count_q;

endmodule

// File: tb/tb_traffic_light_monitor.sv
// tb/tb_traffic_light_monitor.sv - directed and randomized checks of traffic_light_monitor against a reference model
module tb_traffic_light_monitor;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       en = 1'b0;
  logic       clr = 1'b0;
  logic [1:0] la = 2'b00;
  logic [1:0] lb = 2'b00;
  logic       err_conflict;
  logic [1:0] err_seq, err_dwell, err_code;
  logic       err_sticky;
  logic [7:0] viol_count;

  traffic_light_monitor #(
    .GREEN_MIN (3),
    .YELLOW_MIN(2),
    .CNT_W     (8)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .en          (en),
    .clr         (clr),
    .la          (la),
    .lb          (lb),
    .err_conflict(err_conflict),
    .err_seq     (err_seq),
    .err_dwell   (err_dwell),
    .err_code    (err_code),
    .err_sticky  (err_sticky),
    .viol_count  (viol_count)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference history: last light seen per road and how many samples it has lasted.
  int m_last[2];
  int m_run[2];
  int e_conflict, e_seq, e_dwell, e_code, e_sticky, e_count;

  task automatic check(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs != exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0d expected %0d", tag, $time, obs, exp);
    end
  endtask

  // Legal successor of a light when it changes: R->G->Y->R.
  function automatic int successor(input int l);
    if (l == 0) return 2;
    if (l == 2) return 1;
    return 0;
  endfunction

  function automatic int min_dwell(input int l);
    if (l == 2) return 3;
    if (l == 1) return 2;
    return 0;
  endfunction

  task automatic model_reset();
    for (int r = 0; r < 2; r++) begin
      m_last[r] = 0;
      m_run[r]  = 0;
    end
    e_conflict = 0; e_seq = 0; e_dwell = 0; e_code = 0; e_sticky = 0; e_count = 0;
  endtask

  task automatic model_step(input int a, input int b, input bit e, input bit c);
    int cur[2];
    int s, d, k, bad;
    cur[0] = a; cur[1] = b;
    s = 0; d = 0; k = 0;
    for (int r = 0; r < 2; r++) begin
      if (cur[r] == 3) k |= (1 << r);
      if (cur[r] != m_last[r] && cur[r] != 3 && m_last[r] != 3) begin
        if (cur[r] != successor(m_last[r])) s |= (1 << r);
        else if (m_run[r] < min_dwell(m_last[r])) d |= (1 << r);
      end
      if (cur[r] == m_last[r]) m_run[r] = (m_run[r] >= 255) ? 255 : m_run[r] + 1;
      else begin
        m_run[r]  = 1;
        m_last[r] = cur[r];
      end
    end
    e_conflict = (e && a != 0 && b != 0) ? 1 : 0;
    e_seq   = e ? s : 0;
    e_dwell = e ? d : 0;
    e_code  = e ? k : 0;
    bad = e_conflict + e_seq + e_dwell + e_code;
    if (bad != 0) begin
      e_sticky = 1;
      e_count  = c ? 1 : ((e_count >= 255) ? 255 : e_count + 1);
    end else if (c && e) begin
      e_sticky = 0;
      e_count  = 0;
    end
  endtask

  task automatic compare_all(input string tag);
    check({tag, ".conflict"}, int'(err_conflict), e_conflict);
    check({tag, ".seq"},      int'(err_seq),      e_seq);
    check({tag, ".dwell"},    int'(err_dwell),    e_dwell);
    check({tag, ".code"},     int'(err_code),     e_code);
    check({tag, ".sticky"},   int'(err_sticky),   e_sticky);
    check({tag, ".count"},    int'(viol_count),   e_count);
  endtask

  // Called at a negedge; returns at the following negedge.
  task automatic step(input string tag, input int a, input int b, input bit e, input bit c);
    la = 2'(a); lb = 2'(b); en = e; clr = c;
    @(posedge clk);
    model_step(a, b, e, c);
    #1;
    compare_all(tag);
    @(negedge clk);
  endtask

  task automatic do_reset(input int cycles);
    reset = 1'b0;
    #1;
    model_reset();
    compare_all("reset");
    repeat (cycles) @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    int a, b, r;
    bit e, c;
    @(negedge clk);
    do_reset(2);

    // clean cycle through G/Y/R with legal dwell
    repeat (3) step("t1_g", 2, 0, 1, 0);
    repeat (2) step("t1_y", 1, 0, 1, 0);
    repeat (2) step("t1_r", 0, 0, 1, 0);

    // both roads non-red
    step("t2_conf", 2, 1, 1, 0);
    step("t2_idle", 0, 0, 1, 0);

    // G->R is out of order; then Y straight out of reset
    repeat (3) step("t3_g", 2, 0, 1, 0);
    step("t3_gr", 0, 0, 1, 0);
    do_reset(2);
    step("t3_y_after_rst", 1, 0, 1, 0);
    step("t3_r", 0, 0, 1, 0);

    // short green, then short yellow
    repeat (2) step("t4_g", 2, 0, 1, 0);
    step("t4_gy_short", 1, 0, 1, 0);
    step("t4_yr_short", 0, 0, 1, 0);

    // illegal code in and out
    step("t5_code", 3, 0, 1, 0);
    step("t5_back", 0, 0, 1, 0);

    // en low keeps history: G x2 unchecked, then Y checked as short dwell
    step("t7_g_off", 2, 0, 0, 0);
    step("t7_g_off", 2, 0, 0, 0);
    step("t7_y_on", 1, 0, 1, 0);
    step("t7_y", 1, 0, 1, 0);
    step("t7_r", 0, 0, 1, 0);

    // saturation, clear on an error edge, clear on a clean edge
    step("t6_lb_g", 0, 2, 1, 0);
    repeat (300) step("t6_sat", 2, 2, 1, 0);
    check("t6_saturated", int'(viol_count), 255);
    step("t6_clr_err", 2, 2, 1, 1);
    check("t6_clr_err_count", int'(viol_count), 1);
    repeat (2) step("t6_ay", 1, 2, 1, 0);
    step("t6_clr_clean", 0, 2, 1, 1);
    check("t6_clr_clean_count", int'(viol_count), 0);

    // randomized traffic, mostly plausible sequences with occasional faults
    a = 0; b = 0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 399) == 0) begin
        do_reset(1 + $urandom_range(0, 1));
        a = 0; b = 0;
      end
      r = $urandom_range(0, 19);
      if (r < 3) a = successor(a % 3 == a ? a : 0);
      else if (r == 3) a = $urandom_range(0, 3);
      r = $urandom_range(0, 19);
      if (r < 2) b = successor(b == 3 ? 0 : b);
      else if (r == 2) b = $urandom_range(0, 3);
      e = ($urandom_range(0, 9) != 0);
      c = e && ($urandom_range(0, 24) == 0);
      step("rand", a, b, e, c);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
